vga_plot_sink: RTL
==================

// Module: vga_plot_sink
// PURPOSE
// Consumer end of the pixel-plot interface (oX/oY/oColour/oPlot) that the
// vgadisplay engine drives. Accepts one plot request per cycle, clips it,
// buffers it in a FIFO, and drains it to a 160x120 framebuffer write port
// using a write/grant handshake. Also provides a whole-screen clear engine.
// Sits between vgadisplay and the framebuffer memory / scan-out arbiter.
// PARAMETERS
// DEPTH   16   FIFO entries (power of two)
// AW      4    log2(DEPTH)
// WIDTH   160  visible columns; iX >= WIDTH is clipped
// HEIGHT  120  visible rows; iY >= HEIGHT is clipped
// PORTS
// iClock        in   1   system clock, 50 MHz
// iResetn       in   1   asynchronous, active-low reset
// iX            in   8   plot column
// iY            in   7   plot row
// iColour       in   3   plot colour {R,G,B}
// iPlot         in   1   plot request, valid this cycle
// iClear        in   1   one-cycle pulse: start whole-screen clear
// iClearColour  in   3   colour for clear, sampled with iClear
// iMemGrant     in   1   framebuffer accepted the write this cycle
// oMemAddr      out  15  write address = iY*160 + iX
// oMemData      out  3   write colour
// oMemWe        out  1   write request; addr/data stable until granted
// oBusy         out  1   state!=IDLE or FIFO non-empty or clear pending
// oOverflow     out  1   sticky: an in-range plot was lost to a full FIFO
// oDropCount    out  8   clipped-plot count, saturates at 255
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE, clear not pending, oMemWe=0, oMemAddr=0,
//   oMemData=0, oBusy=0, oOverflow=0, oDropCount=0. Reset mid-write or
//   mid-clear aborts immediately; no further writes issued.
// - Accept: iPlot=1 and in range -> push {addr,colour}. Address computed
//   before push: (iY<<7)+(iY<<5)+iX, 15 bits, no overflow (max 19199).
// - Clip: iPlot=1 and out of range -> not pushed, oDropCount+1 (saturate).
// - Full: push allowed if count<DEPTH or a pop occurs the same cycle;
//   otherwise plot lost and oOverflow set (held until reset).
// - Plots keep being accepted/buffered in every state, including CLEAR.
// - Handshake: oMemWe, oMemAddr, oMemData combinational from state and
//   FIFO head / clear counter. Transfer occurs on a cycle with oMemWe=1
//   and iMemGrant=1. Without a grant, outputs hold; no timeout.
// - FSM IDLE: clear pending -> CLEAR (counter=0); else FIFO non-empty ->
//   DRAIN. oMemWe=0.
// - FSM DRAIN: oMemWe=1 with FIFO head. On grant pop; then clear pending
//   -> CLEAR, else FIFO empty after pop -> IDLE, else stay (1 write/cycle).
// - FSM CLEAR: oMemWe=1, addr=counter, data=latched clear colour. On
//   grant counter+1; grant at counter=19199 -> IDLE, pending cleared.
// - iClear in IDLE/DRAIN: latch colour, set pending (taken after current
//   DRAIN transfer). iClear while in CLEAR or already pending: ignored.
// - Latency: iPlot in cycle N into empty FIFO in IDLE -> oMemWe=1 in N+2.
// TESTING
// 1 Reset then iPlot x=5,y=2,c=3'b101, grant tied 1 -> oMemWe=1 two cycles
//   later, addr=325, data=5; oBusy returns 0 one cycle after the grant.
// 2 iPlot x=160,y=0 and x=0,y=120 -> no write, oDropCount=2; 300 clipped
//   plots -> oDropCount=255.
// 3 Grant 0, 17 back-to-back in-range plots -> 16 buffered, oOverflow=1;
//   grant 1 -> exactly 16 writes in push order, one per cycle.
// 4 iClear colour 3'b010, grant 1 -> 19200 writes, addr 0..19199, data 2;
//   then IDLE, oBusy=0.
// 5 iClear while DRAIN holds 3 entries -> current entry written, then
//   full clear, then remaining 2 entries; plots during clear drained after.
// 6 iResetn low mid-clear (addr 500) -> oMemWe=0 immediately; after
//   release no write until new plot/clear; all outputs at reset values.

Source files
------------

// File: rtl/vga_plot_sink_if.sv
// Plot-request and framebuffer-write bundle between the vgadisplay engine,
// the plot sink and the framebuffer write port.
interface vga_plot_sink_if;
    logic [7:0]  iX;
    logic [6:0]  iY;
    logic [2:0]  iColour;
    logic        iPlot;
    logic        iClear;
    logic [2:0]  iClearColour;
    logic        iMemGrant;
    logic [14:0] oMemAddr;
    logic [2:0]  oMemData;
    logic        oMemWe;
    logic        oBusy;
    logic        oOverflow;
    logic [7:0]  oDropCount;

    // Driver side: plot source plus framebuffer grant.
    modport master (
        output iX, iY, iColour, iPlot, iClear, iClearColour, iMemGrant,
        input  oMemAddr, oMemData, oMemWe, oBusy, oOverflow, oDropCount
    );

    // Sink side: the plot sink itself.
    modport slave (
        input  iX, iY, iColour, iPlot, iClear, iClearColour, iMemGrant,
        output oMemAddr, oMemData, oMemWe, oBusy, oOverflow, oDropCount
    );
endinterface

// File: rtl/vga_plot_sink.sv
// Plot sink: clips incoming plot requests, buffers them in a small FIFO and
// drains them to a 160x120 framebuffer write port with a write/grant
// handshake. A clear request paints the whole screen with one colour.
module vga_plot_sink #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic           iClock,
    input  logic           iResetn,
    vga_plot_sink_if.slave bus
);

    localparam logic [7:0]  WIDTH_L   = 8'(WIDTH);
    localparam logic [6:0]  HEIGHT_L  = 7'(HEIGHT);
    localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t        state_reg;
    logic [17:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          clear_pending_reg;
    logic [2:0]    clear_colour_reg;
    logic [14:0]   clear_addr_reg;
    logic          overflow_reg;
    logic [7:0]    drop_count_reg;

    logic          in_range;
    logic [14:0]   plot_addr;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          lost;
    logic          clip;
    logic          clear_accept;
    logic          clear_req;
    logic [17:0]   head;
    logic          mem_we;
    logic [14:0]   mem_addr;
    logic [2:0]    mem_data;

    // Request classification and FIFO bookkeeping.
    always_comb begin
        in_range     = (bus.iX < WIDTH_L) && (bus.iY < HEIGHT_L);
        // y*160 as shift-and-add; the largest in-range result fits 15 bits.
        plot_addr    = ({8'd0, bus.iY} << 7) + ({8'd0, bus.iY} << 5) + {7'd0, bus.iX};
        fifo_full    = (count_reg == FULL_CNT);
        pop          = (state_reg == DRAIN) && bus.iMemGrant;
        push         = bus.iPlot && in_range && (!fifo_full || pop);
        lost         = bus.iPlot && in_range && !push;
        clip         = bus.iPlot && !in_range;
        count_next   = count_reg + (AW + 1)'(push) - (AW + 1)'(pop);
        // A clear arriving this cycle counts as pending immediately, so a
        // grant in the same cycle hands over to the clear without an extra
        // FIFO write slipping in.
        clear_accept = bus.iClear && !clear_pending_reg && (state_reg != CLEAR);
        clear_req    = clear_pending_reg || clear_accept;
        head         = fifo_mem[rd_ptr_reg];
    end

    // Write-port outputs are decoded straight from state so they stay stable
    // for as long as the grant is withheld.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        case (state_reg)
            DRAIN: begin
                mem_we   = 1'b1;
                mem_addr = head[17:3];
                mem_data = head[2:0];
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clear_addr_reg;
                mem_data = clear_colour_reg;
            end
            default: ;
        endcase
    end

    assign bus.oMemWe     = mem_we;
    assign bus.oMemAddr   = mem_addr;
    assign bus.oMemData   = mem_data;
    assign bus.oBusy      = (state_reg != IDLE) || (count_reg != '0) || clear_pending_reg;
    assign bus.oOverflow  = overflow_reg;
    assign bus.oDropCount = drop_count_reg;

    // FIFO storage: small array with an asynchronous head read so the
    // current entry is visible on the write port in the same cycle.
    always_ff @(posedge iClock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {plot_addr, bus.iColour};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Sticky overflow flag and saturating clipped-plot counter.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if (lost) begin
                overflow_reg <= 1'b1;
            end
            if (clip && (drop_count_reg != 8'hFF)) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end
        end
    end

    // Drain/clear sequencer, including the clear request latch.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_reg         <= IDLE;
            clear_pending_reg <= 1'b0;
            clear_colour_reg  <= '0;
            clear_addr_reg    <= '0;
        end else begin
            if (clear_accept) begin
                clear_pending_reg <= 1'b1;
                clear_colour_reg  <= bus.iClearColour;
            end
            case (state_reg)
                IDLE: begin
                    if (clear_req) begin
                        state_reg      <= CLEAR;
                        clear_addr_reg <= '0;
                    end else if (count_reg != '0) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        if (clear_req) begin
                            state_reg      <= CLEAR;
                            clear_addr_reg <= '0;
                        end else if (count_next == '0) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                CLEAR: begin
                    if (bus.iMemGrant) begin
                        if (clear_addr_reg == LAST_ADDR) begin
                            state_reg         <= IDLE;
                            clear_pending_reg <= 1'b0;
                        end else begin
                            clear_addr_reg <= clear_addr_reg + 15'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
